mccoy_sequencer: RTL and testbench
==================================

Name: mccoy_sequencer

Overview:
Multi-cycle control FSM for the McCoy core. It owns the program counter and loads the instruction memory from the 6-bit input bus. It sequences each instruction through FETCH/EXEC/WB and gates the decoder's write-enable and branch controls into single-cycle strobes. Sits between the top-level pin wrapper, instruction memory, decoder and register file/x8.

Parameters:
PC_W, 4, program counter / instruction memory address width (depth 2^PC_W)
INSTR_W, 6, instruction width; opcode = instr[INSTR_W-1 -: 3]

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
load_mode  in  1  level; 1 requests program-load mode
load_valid  in  1  one instruction word presented this cycle (LOAD only)
load_data  in  INSTR_W  instruction word to store
run  in  1  level; 1 = free-run execution
step  in  1  single-step request; rising edge detected internally
ir_opcode  in  3  opcode of the instruction register (3'b111 = halt)
dec_bez  in  1  decoder bez
dec_ja  in  1  decoder ja
dec_write_reg  in  1  decoder writeReg
dec_write_x8  in  1  decoder writex8
x8_zero  in  1  x8 == 0
branch_target  in  PC_W  target address from the datapath
imem_we  out  1  instruction memory write strobe
imem_addr  out  PC_W  load pointer in LOAD, else pc
imem_wdata  out  INSTR_W  equals load_data
ir_en  out  1  instruction register load strobe
reg_we  out  1  register-file write strobe
x8_we  out  1  x8 write strobe
pc  out  PC_W  program counter
busy  out  1  1 in FETCH/EXEC/WB
halted  out  1  1 in HALT
instr_count  out  16  retired-instruction count (optional feature)

Behaviour:
- States: IDLE, LOAD, FETCH, EXEC, WB, HALT. Reset -> IDLE, pc=0, load pointer=0, step_q=0, all strobes 0, busy=0, halted=0, instr_count=0.
- Reset is asynchronous and may assert mid-instruction or mid-load. The FSM returns to IDLE with no strobe emitted. Memory contents are not touched.
- IDLE priority: load_mode -> LOAD (pointer cleared to 0). Else run -> FETCH. Else a step rising edge (step & ~step_q) -> FETCH with single flag set.
- LOAD: imem_we = load_valid (combinational). imem_addr = pointer; pointer += 1 per valid word, wrapping mod 2^PC_W. load_mode=0 -> IDLE with pc=0. run and step are ignored in LOAD.
- Instruction latency is 3 cycles.
  - FETCH: ir_en=1 for one cycle; imem_addr=pc.
  - EXEC: no strobes; datapath settles. If ir_opcode==3'b111 -> HALT; pc is unchanged and the instruction is not counted.
  - WB: reg_we = dec_write_reg and x8_we = dec_write_x8, each for exactly one cycle. pc <= branch_target if dec_ja | (dec_bez & x8_zero), else pc+1 mod 2^PC_W (wraps 2^PC_W-1 -> 0).
- After WB: if single flag set or run=0 -> IDLE (single flag cleared). Otherwise -> FETCH.
- load_mode asserted while busy is ignored until IDLE. The current instruction always completes.
- HALT: halted=1; stays until rst_n, or until load_mode=1 -> LOAD (pc=0, halted=0).
- Strobes are mutually exclusive by state. ir_en, reg_we and x8_we are never high outside FETCH/WB.

Optional Feature:
MCCOY_INSTR_COUNT_EN
- Defined: instr_count increments by 1 at every WB and saturates at 16'hFFFF. It clears to 0 on entry to LOAD and on reset.
- Undefined: the counter logic is removed and instr_count is tied to 16'h0000.

Test Plan:
- Load 3 words 6'h08, 6'h19, 6'h38 with load_mode=1 and 3 load_valid pulses -> imem_we at addr 0,1,2 with matching data. After load_mode=0: pc=0, state IDLE.
- run=1 with non-branch opcode 3'b000 and dec_write_x8=1 -> ir_en cycle 1, x8_we only in cycle 3. pc 0 -> 1 after WB, then ir_en again on cycle 4.
- bez with x8_zero=1 and branch_target=4'hA -> pc=4'hA after WB. Same with x8_zero=0 -> pc=prev+1.
- pc=4'hF, non-branch -> pc wraps to 4'h0. Load of 17 words -> 17th write goes to addr 0.
- step held high for 5 cycles, run=0 -> exactly one instruction executes (one ir_en), then IDLE. No second instruction until step falls and rises again.
- ir_opcode=3'b111 -> HALT, halted=1, no reg_we/x8_we, pc unchanged. rst_n low mid-EXEC -> IDLE immediately, pc=0. With MCCOY_INSTR_COUNT_EN, after 5 retired instructions instr_count=5.

Source files
------------

// File: rtl/mccoy_sequencer_if.sv
// -----------------------------------------------------------------------------
// mccoy_sequencer_if
// Program-load / instruction-memory bus between the McCoy sequencer and the
// instruction memory.
//   load_valid  one instruction word presented this cycle (program load)
//   load_data   instruction word to store
//   imem_we     instruction memory write strobe
//   imem_addr   instruction memory address (load pointer or pc)
//   imem_wdata  instruction memory write data
// Modports:
//   master  sequencer side (drives the imem_* signals)
//   slave   memory / pin-wrapper side (drives the load_* signals)
// -----------------------------------------------------------------------------
interface mccoy_sequencer_if #(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned INSTR_W = 6
);
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               imem_we;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        input  load_valid,
        input  load_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output load_valid,
        output load_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/mccoy_sequencer.sv
// -----------------------------------------------------------------------------
// mccoy_sequencer
// Multi-cycle control FSM of the McCoy core. Owns the program counter, loads
// the instruction memory word by word, and walks each instruction through
// FETCH / EXEC / WB, turning the decoder's write and branch controls into
// single-cycle strobes.
//
// Optional feature (compile-time macro MCCOY_INSTR_COUNT_EN):
//   defined   -> instr_count_o counts retired instructions, saturating at
//                16'hFFFF, cleared on reset and on every entry to LOAD
//   undefined -> instr_count_o is tied to 16'h0000
//
// Ports:
//   clk              core clock, rising edge
//   rst_n            asynchronous active-low reset
//   bus              instruction-memory / load bus (master modport)
//   load_mode_i      level, requests program-load mode
//   run_i            level, free-run execution
//   step_i           single-step request (rising edge detected internally)
//   ir_opcode_i      opcode of the instruction register (3'b111 = halt)
//   dec_bez_i        decoder branch-if-x8-zero
//   dec_ja_i         decoder jump-absolute
//   dec_write_reg_i  decoder register-file write
//   dec_write_x8_i   decoder x8 write
//   x8_zero_i        x8 == 0
//   branch_target_i  branch target from the datapath
//   ir_en_o          instruction register load strobe (FETCH)
//   reg_we_o         register-file write strobe (WB)
//   x8_we_o          x8 write strobe (WB)
//   pc_o             program counter
//   busy_o           high while an instruction is in flight
//   halted_o         high in HALT
//   instr_count_o    retired-instruction count
// -----------------------------------------------------------------------------
module mccoy_sequencer #(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned INSTR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    mccoy_sequencer_if.master bus,
    input  logic             load_mode_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic [2:0]       ir_opcode_i,
    input  logic             dec_bez_i,
    input  logic             dec_ja_i,
    input  logic             dec_write_reg_i,
    input  logic             dec_write_x8_i,
    input  logic             x8_zero_i,
    input  logic [PC_W-1:0]  branch_target_i,
    output logic             ir_en_o,
    output logic             reg_we_o,
    output logic             x8_we_o,
    output logic [PC_W-1:0]  pc_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [15:0]      instr_count_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam logic [2:0]      OpHalt = 3'b111;
    localparam logic [PC_W-1:0] PcOne  = PC_W'(1);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] ptr_q;
    logic            step_q;
    logic            single_q;
    logic            ir_en_q;
    logic            busy_q;
    logic            halted_q;

    logic step_rise;
    logic take_branch;

    assign step_rise   = step_i & ~step_q;
    assign take_branch = dec_ja_i | (dec_bez_i & x8_zero_i);

`ifdef MCCOY_INSTR_COUNT_EN
    logic [15:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ptr_q    <= '0;
            step_q   <= 1'b0;
            single_q <= 1'b0;
            ir_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef MCCOY_INSTR_COUNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            // step is sampled every cycle so an edge seen while busy never
            // fires late once the sequencer returns to IDLE.
            step_q  <= step_i;
            ir_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_mode_i) begin
                        state_q <= StLoad;
                        ptr_q   <= '0;
`ifdef MCCOY_INSTR_COUNT_EN
                        cnt_q   <= '0;
`endif
                    end else if (run_i || step_rise) begin
                        state_q  <= StFetch;
                        ir_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        // run has priority, so only a pure step sets single
                        single_q <= ~run_i;
                    end
                end
                StLoad: begin
                    if (bus.load_valid) begin
                        ptr_q <= ptr_q + PcOne;
                    end
                    if (!load_mode_i) begin
                        state_q <= StIdle;
                        pc_q    <= '0;
                    end
                end
                StFetch: begin
                    state_q <= StExec;
                end
                StExec: begin
                    if (ir_opcode_i == OpHalt) begin
                        state_q  <= StHalt;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    pc_q <= take_branch ? branch_target_i : pc_q + PcOne;
`ifdef MCCOY_INSTR_COUNT_EN
                    if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                    if (single_q || !run_i) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        single_q <= 1'b0;
                    end else begin
                        state_q <= StFetch;
                        ir_en_q <= 1'b1;
                    end
                end
                StHalt: begin
                    if (load_mode_i) begin
                        state_q  <= StLoad;
                        pc_q     <= '0;
                        ptr_q    <= '0;
                        halted_q <= 1'b0;
`ifdef MCCOY_INSTR_COUNT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memory writes follow load_valid directly so each presented word lands
    // in the same cycle it is offered.
    assign bus.imem_we    = (state_q == StLoad) & bus.load_valid;
    assign bus.imem_addr  = (state_q == StLoad) ? ptr_q : pc_q;
    assign bus.imem_wdata = bus.load_data;

    assign ir_en_o  = ir_en_q;
    assign reg_we_o = (state_q == StWb) & dec_write_reg_i;
    assign x8_we_o  = (state_q == StWb) & dec_write_x8_i;
    assign pc_o     = pc_q;
    assign busy_o   = busy_q;
    assign halted_o = halted_q;

`ifdef MCCOY_INSTR_COUNT_EN
    assign instr_count_o = cnt_q;
`else
    assign instr_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_mccoy_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mccoy_sequencer
// Scoreboard bench for mccoy_sequencer. Stimulus tasks predict every strobe
// event (memory write, fetch, write-back) from a transaction-level model and
// queue it; a monitor pops and compares whenever the DUT raises a strobe.
// Architectural state (pc, busy, halted, instr_count) is checked at the end
// of each operation.
// -----------------------------------------------------------------------------
module tb_mccoy_sequencer;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned INSTR_W = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_mode = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [2:0]  ir_opcode = 3'b000;
    logic        dec_bez = 1'b0;
    logic        dec_ja = 1'b0;
    logic        dec_write_reg = 1'b0;
    logic        dec_write_x8 = 1'b0;
    logic        x8_zero = 1'b0;
    logic [3:0]  branch_target = 4'h0;
    logic        ir_en;
    logic        reg_we;
    logic        x8_we;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    mccoy_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    mccoy_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .load_mode_i     (load_mode),
        .run_i           (run),
        .step_i          (step),
        .ir_opcode_i     (ir_opcode),
        .dec_bez_i       (dec_bez),
        .dec_ja_i        (dec_ja),
        .dec_write_reg_i (dec_write_reg),
        .dec_write_x8_i  (dec_write_x8),
        .x8_zero_i       (x8_zero),
        .branch_target_i (branch_target),
        .ir_en_o         (ir_en),
        .reg_we_o        (reg_we),
        .x8_we_o         (x8_we),
        .pc_o            (pc),
        .busy_o          (busy),
        .halted_o        (halted),
        .instr_count_o   (instr_count)
    );

    always #5 clk = ~clk;

    // kind 0 = memory write (a=addr, d=data); 1 = fetch (a=pc, d=expected
    // cycles since previous fetch, 0 = don't care); 2 = write-back (a=pc).
    typedef struct {
        int         kind;
        logic [3:0] a;
        logic [5:0] d;
        logic       rw;
        logic       xw;
    } ev_t;

    typedef struct {
        logic [2:0] op;
        logic       ja;
        logic       bez;
        logic       z;
        logic       wr;
        logic       wx;
        logic [3:0] tgt;
    } dec_t;

    ev_t        exp_q[$];
    dec_t       dq[$];
    logic [5:0] ld_q[$];

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] m_pc = 4'h0;
    int         m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef MCCOY_INSTR_COUNT_EN
        return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic dec_t rand_dec();
        dec_t d;
        d.op  = 3'($urandom_range(0, 6));
        d.ja  = ($urandom_range(0, 3) == 0);
        d.bez = 1'($urandom);
        d.z   = 1'($urandom);
        d.wr  = 1'($urandom);
        d.wx  = 1'($urandom);
        d.tgt = 4'($urandom);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input dec_t d);
        ir_opcode     = d.op;
        dec_ja        = d.ja;
        dec_bez       = d.bez;
        x8_zero       = d.z;
        dec_write_reg = d.wr;
        dec_write_x8  = d.wx;
        branch_target = d.tgt;
    endtask

    task automatic check_idle(input string name);
        check({name, "_pc"}, 32'(pc), 32'(m_pc));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_halted"}, 32'(halted), 32'd0);
        check({name, "_count"}, 32'(instr_count), 32'(exp_cnt()));
    endtask

    // Retire (or squash) one decoded instruction in the model.
    task automatic model_retire(input dec_t d);
        if (d.wr || d.wx) exp_q.push_back('{kind: 2, a: m_pc, d: 6'd0, rw: d.wr, xw: d.wx});
        m_pc = (d.ja || (d.bez && d.z)) ? d.tgt : 4'(m_pc + 4'd1);
        m_cnt++;
    endtask

    // Loads every word queued in ld_q, with random idle gaps and random
    // run/step noise that LOAD must ignore.
    task automatic do_load();
        logic [3:0] ptr;
        ptr = 4'h0;
        load_mode = 1'b1;
        tick();
        m_cnt = 0;
        while (ld_q.size() > 0) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 6'($urandom);
            end else begin
                bus.load_valid = 1'b1;
                bus.load_data  = ld_q.pop_front();
                exp_q.push_back('{kind: 0, a: ptr, d: bus.load_data, rw: 1'b0, xw: 1'b0});
                ptr = 4'(ptr + 4'd1);
            end
            run  = 1'($urandom);
            step = 1'($urandom);
            tick();
        end
        bus.load_valid = 1'b0;
        load_mode      = 1'b0;
        run            = 1'b0;
        step           = 1'b0;
        tick();
        m_pc = 4'h0;
        check_idle("load_exit");
    endtask

    // Free-runs n instructions (decode from dq, else random); optionally
    // makes the last one a halt.
    task automatic run_prog(input int n, input bit halt_last);
        dec_t d;
        run = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            d = (dq.size() > 0) ? dq.pop_front() : rand_dec();
            if (halt_last && i == n - 1) d.op = 3'b111;
            exp_q.push_back('{kind: 1, a: m_pc, d: (i == 0) ? 6'd0 : 6'd3, rw: 1'b0, xw: 1'b0});
            drive(d);
            if (i == n - 1) run = 1'b0;
            if (d.op == 3'b111) begin
                tick();
                tick();
                check("halt_halted", 32'(halted), 32'd1);
                check("halt_busy", 32'(busy), 32'd0);
                check("halt_pc", 32'(pc), 32'(m_pc));
                check("halt_count", 32'(instr_count), 32'(exp_cnt()));
                return;
            end
            model_retire(d);
            tick();
            tick();
            tick();
        end
        check_idle("run_end");
    endtask

    task automatic step_once();
        dec_t d;
        d = rand_dec();
        run  = 1'b0;
        step = 1'b1;
        tick();
        exp_q.push_back('{kind: 1, a: m_pc, d: 6'd0, rw: 1'b0, xw: 1'b0});
        drive(d);
        model_retire(d);
        repeat (4) tick();
        step = 1'b0;
        tick();
        tick();
        check_idle("step_end");
    endtask

    task automatic reset_mid_exec();
        dec_t d;
        d    = rand_dec();
        d.wr = 1'b1;
        d.wx = 1'b1;
        run  = 1'b1;
        tick();
        exp_q.push_back('{kind: 1, a: m_pc, d: 6'd0, rw: 1'b0, xw: 1'b0});
        drive(d);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        m_pc  = 4'h0;
        m_cnt = 0;
        check("rst_exec_pc", 32'(pc), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_count", 32'(instr_count), 32'd0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("rst_exec_after");
    endtask

    // Monitor: compare every strobe the DUT raises against the queue head.
    initial begin
        int  cyc;
        int  last_fetch;
        int  nstr;
        ev_t e;
        cyc        = 0;
        last_fetch = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                nstr = int'(bus.imem_we) + int'(ir_en) + int'(reg_we | x8_we);
                if (nstr > 0) check("strobe_exclusive", 32'(nstr), 32'd1);
                if (bus.imem_we) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 32'(bus.imem_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_kind", 32'd0, 32'(e.kind));
                        check("write_addr", 32'(bus.imem_addr), 32'(e.a));
                        check("write_data", 32'(bus.imem_wdata), 32'(e.d));
                    end
                end
                if (ir_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_fetch", 32'(pc), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("fetch_kind", 32'd1, 32'(e.kind));
                        check("fetch_pc", 32'(pc), 32'(e.a));
                        check("fetch_addr", 32'(bus.imem_addr), 32'(e.a));
                        if (e.d != 6'd0) check("fetch_spacing", 32'(cyc - last_fetch), 32'(e.d));
                    end
                    last_fetch = cyc;
                end
                if (reg_we || x8_we) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wb", {30'd0, reg_we, x8_we}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_kind", 32'd2, 32'(e.kind));
                        check("wb_pc", 32'(pc), 32'(e.a));
                        check("wb_strobes", {30'd0, reg_we, x8_we}, {30'd0, e.rw, e.xw});
                        check("wb_latency", 32'(cyc - last_fetch), 32'd2);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual running required finished");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = 6'h00;
        #12;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_strobes", {28'd0, bus.imem_we, ir_en, reg_we, x8_we}, 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed three-word load, then plain, branching and wrapping runs.
        ld_q = '{6'h08, 6'h19, 6'h38};
        do_load();
        dq.push_back('{op: 3'b000, ja: 1'b0, bez: 1'b0, z: 1'b0, wr: 1'b0, wx: 1'b1, tgt: 4'h7});
        dq.push_back('{op: 3'b000, ja: 1'b0, bez: 1'b0, z: 1'b1, wr: 1'b1, wx: 1'b0, tgt: 4'h3});
        run_prog(2, 1'b0);
        dq.push_back('{op: 3'b010, ja: 1'b0, bez: 1'b1, z: 1'b1, wr: 1'b0, wx: 1'b0, tgt: 4'hA});
        dq.push_back('{op: 3'b010, ja: 1'b0, bez: 1'b1, z: 1'b0, wr: 1'b1, wx: 1'b0, tgt: 4'h5});
        run_prog(2, 1'b0);
        dq.push_back('{op: 3'b011, ja: 1'b1, bez: 1'b0, z: 1'b0, wr: 1'b0, wx: 1'b0, tgt: 4'hF});
        dq.push_back('{op: 3'b000, ja: 1'b0, bez: 1'b0, z: 1'b1, wr: 1'b0, wx: 1'b1, tgt: 4'h9});
        run_prog(2, 1'b0);

        // 17-word load wraps the pointer; then five retired instructions.
        for (int i = 0; i < 17; i++) ld_q.push_back(6'($urandom));
        do_load();
        run_prog(5, 1'b0);

        step_once();
        step_once();

        // Halt with write controls asserted: no write-back, pc frozen.
        dq.push_back('{op: 3'b001, ja: 1'b0, bez: 1'b0, z: 1'b0, wr: 1'b0, wx: 1'b0, tgt: 4'h2});
        dq.push_back('{op: 3'b111, ja: 1'b1, bez: 1'b1, z: 1'b1, wr: 1'b1, wx: 1'b1, tgt: 4'h6});
        run_prog(2, 1'b1);
        run  = 1'b1;
        step = 1'b1;
        repeat (3) tick();
        check("halt_hold_halted", 32'(halted), 32'd1);
        check("halt_hold_pc", 32'(pc), 32'(m_pc));
        run  = 1'b0;
        step = 1'b0;
        ld_q = '{6'h3F, 6'h01};
        do_load();

        reset_mid_exec();

        // Randomised rounds.
        for (int r = 0; r < 10; r++) begin
            int nw;
            nw = $urandom_range(1, 20);
            for (int i = 0; i < nw; i++) ld_q.push_back(6'($urandom));
            do_load();
            run_prog($urandom_range(1, 6), ($urandom_range(0, 2) == 0));
            if (!halted && ($urandom_range(0, 1) == 1)) step_once();
        end

        repeat (5) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
